shift_reg_serializer_ctrl: RTL and testbench

//   Controller that sequences a parallel-load shift register to turn WIDTH-bit words into a serial bit stream.

---
 rtl/shift_ctrl_pkg.sv | 25 ++
 rtl/shift_reg_piso.sv | 45 ++++
 rtl/shift_reg_serializer_ctrl.sv | 160 ++++++++++++++++
 tb/tb_shift_reg_serializer_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the word-to-bit serializer controller and its shift register.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_ctrl_pkg;

   // Controller FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Shift-register operation selected by the controller each cycle
   typedef enum logic [1:0] {
      MD_HOLD  = 2'd0,
      MD_LOAD  = 2'd1,
      MD_SHIFT = 2'd2
   } shift_mode_t;

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int cnt_bits(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/shift_reg_piso.sv
// Parallel-in serial-out shift register driven by an explicit hold/load/shift mode.
// Latency: load or shift takes effect at the next rising edge; o_ser is a pure decode of the register.
// Backpressure: none here; the controller holds the register with MD_HOLD while downstream stalls.
module shift_reg_piso
   import shift_ctrl_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  shift_mode_t      i_mode,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_ser
);

   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] w_shifted;

   // Next value of the register when one bit is consumed: the sent bit falls off the
   // output end and a zero enters from the other side.
   generate
      if (MSB_FIRST) begin : g_msb
         assign w_shifted = {r_sr[WIDTH-2:0], 1'b0};
         assign o_ser     = r_sr[WIDTH-1];
      end else begin : g_lsb
         assign w_shifted = {1'b0, r_sr[WIDTH-1:1]};
         assign o_ser     = r_sr[0];
      end
   endgenerate

   // Register update: load a new word, advance one bit, or hold through a stall
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sr <= '0;
      end else begin
         case (i_mode)
            MD_LOAD:  r_sr <= i_data;
            MD_SHIFT: r_sr <= w_shifted;
            default:  r_sr <= r_sr;
         endcase
      end
   end

endmodule

// File: rtl/shift_reg_serializer_ctrl.sv
// Serializes WIDTH-bit words into a framed bit stream with optional idle gap between frames.
// Latency: word accepted at edge k -> first bit valid in cycle k+1; a frame is WIDTH accepted bits.
// Backpressure: ser_ready low freezes the current bit and all flags; in_ready drops while a frame is in flight.
module shift_reg_serializer_ctrl
   import shift_ctrl_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int GAP       = 1,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             ser_ready,
   output logic             ser_valid,
   output logic             ser_out,
   output logic             frame_start,
   output logic             frame_end,
   output logic             busy
);

   localparam int CW = cnt_bits(WIDTH);
   localparam int GW = cnt_bits(GAP + 1);

   localparam logic [CW-1:0] CNT_LAST_BIT = CW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_RELOAD   = (GAP > 0) ? GW'(GAP - 1) : '0;
   localparam bit            GAP_EN       = (GAP > 0);

   state_t        r_state;
   logic [CW-1:0] r_bit_cnt;
   logic [GW-1:0] r_gap_cnt;
   logic          r_ser_valid;
   logic          r_frame_start;
   logic          r_frame_end;
   logic          r_busy;

   logic          w_last_bit;
   logic          w_bit_acc;
   logic          w_chain_rdy;
   logic          w_load;
   logic          w_piso_ser;
   shift_mode_t   w_mode;

   // The counter reaches 0 on the final bit of the frame; an accepted final bit ends the frame
   assign w_last_bit  = (r_state == ST_SHIFT) && (r_bit_cnt == '0);
   assign w_bit_acc   = (r_state == ST_SHIFT) && ser_ready;

   // With no gap configured, the next word may be taken on the same edge the last bit leaves
   assign w_chain_rdy = !GAP_EN && w_last_bit && ser_ready;

   assign in_ready    = !reset && ((r_state == ST_IDLE) || w_chain_rdy);
   assign w_load      = in_valid && in_ready;

   // Pick the shift-register operation: a load wins over shifting out the final bit
   always_comb begin
      w_mode = MD_HOLD;
      if (w_load) begin
         w_mode = MD_LOAD;
      end else if (w_bit_acc) begin
         w_mode = MD_SHIFT;
      end
   end

   shift_reg_piso #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_piso (
      .clk    (clk),
      .reset  (reset),
      .i_mode (w_mode),
      .i_data (in_data),
      .o_ser  (w_piso_ser)
   );

   // Frame sequencer: state, bit and gap counters, and the registered status outputs.
   // Outputs are computed for the state being entered so they line up with the bit on ser_out;
   // a stall in SHIFT leaves every register untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_bit_cnt     <= '0;
         r_gap_cnt     <= '0;
         r_ser_valid   <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_end   <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_load) begin
                  r_state       <= ST_SHIFT;
                  r_bit_cnt     <= CNT_LAST_BIT;
                  r_ser_valid   <= 1'b1;
                  r_frame_start <= 1'b1;
                  r_frame_end   <= 1'b0;
                  r_busy        <= 1'b1;
               end
            end

            ST_SHIFT: begin
               if (ser_ready) begin
                  if (r_bit_cnt == '0) begin
                     if (GAP_EN) begin
                        r_state       <= ST_GAP;
                        r_gap_cnt     <= GAP_RELOAD;
                        r_ser_valid   <= 1'b0;
                        r_frame_start <= 1'b0;
                        r_frame_end   <= 1'b0;
                        r_busy        <= 1'b1;
                     end else if (w_load) begin
                        r_bit_cnt     <= CNT_LAST_BIT;
                        r_ser_valid   <= 1'b1;
                        r_frame_start <= 1'b1;
                        r_frame_end   <= 1'b0;
                        r_busy        <= 1'b1;
                     end else begin
                        r_state       <= ST_IDLE;
                        r_ser_valid   <= 1'b0;
                        r_frame_start <= 1'b0;
                        r_frame_end   <= 1'b0;
                        r_busy        <= 1'b0;
                     end
                  end else begin
                     r_bit_cnt     <= r_bit_cnt - 1'b1;
                     r_frame_start <= 1'b0;
                     r_frame_end   <= (r_bit_cnt == CW'(1));
                  end
               end
            end

            ST_GAP: begin
               if (r_gap_cnt == '0) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_gap_cnt <= r_gap_cnt - 1'b1;
               end
            end

            default: begin
               r_state       <= ST_IDLE;
               r_ser_valid   <= 1'b0;
               r_frame_start <= 1'b0;
               r_frame_end   <= 1'b0;
               r_busy        <= 1'b0;
            end
         endcase
      end
   end

   // Serial data is forced low whenever no bit is being offered
   assign ser_out     = w_piso_ser & r_ser_valid;
   assign ser_valid   = r_ser_valid;
   assign frame_start = r_frame_start;
   assign frame_end   = r_frame_end;
   assign busy        = r_busy;

endmodule

// File: tb/tb_shift_reg_serializer_ctrl.sv
// Directed bench for shift_reg_serializer_ctrl: default, back-to-back (GAP=0) and LSB-first instances.
// Each cycle the observed outputs are packed as {ser_valid, ser_out, frame_start, frame_end, in_ready, busy}.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_shift_reg_serializer_ctrl;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   // Instance a: WIDTH=4, GAP=1, MSB first
   logic       a_in_valid, a_in_ready, a_ser_ready, a_ser_valid, a_ser_out, a_fs, a_fe, a_busy;
   logic [3:0] a_in_data;
   // Instance b: WIDTH=4, GAP=0, MSB first
   logic       b_in_valid, b_in_ready, b_ser_ready, b_ser_valid, b_ser_out, b_fs, b_fe, b_busy;
   logic [3:0] b_in_data;
   // Instance c: WIDTH=4, GAP=1, LSB first
   logic       c_in_valid, c_in_ready, c_ser_ready, c_ser_valid, c_ser_out, c_fs, c_fe, c_busy;
   logic [3:0] c_in_data;

   shift_reg_serializer_ctrl #(.WIDTH(4), .GAP(1), .MSB_FIRST(1'b1)) u_dut_a (
      .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
      .ser_ready(a_ser_ready), .ser_valid(a_ser_valid), .ser_out(a_ser_out),
      .frame_start(a_fs), .frame_end(a_fe), .busy(a_busy));

   shift_reg_serializer_ctrl #(.WIDTH(4), .GAP(0), .MSB_FIRST(1'b1)) u_dut_b (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
      .ser_ready(b_ser_ready), .ser_valid(b_ser_valid), .ser_out(b_ser_out),
      .frame_start(b_fs), .frame_end(b_fe), .busy(b_busy));

   shift_reg_serializer_ctrl #(.WIDTH(4), .GAP(1), .MSB_FIRST(1'b0)) u_dut_c (
      .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
      .ser_ready(c_ser_ready), .ser_valid(c_ser_valid), .ser_out(c_ser_out),
      .frame_start(c_fs), .frame_end(c_fe), .busy(c_busy));

   logic [5:0] a_obs, b_obs, c_obs;
   assign a_obs = {a_ser_valid, a_ser_out, a_fs, a_fe, a_in_ready, a_busy};
   assign b_obs = {b_ser_valid, b_ser_out, b_fs, b_fe, b_in_ready, b_busy};
   assign c_obs = {c_ser_valid, c_ser_out, c_fs, c_fe, c_in_ready, c_busy};

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic to_drv();
      @(posedge clk);
      #1;
   endtask

   // Expected per-cycle vectors {v, o, fs, fe, rdy, busy}
   logic [5:0] exp2 [6] = '{6'b111001, 6'b100001, 6'b110001, 6'b110101, 6'b000001, 6'b000010};
   logic [5:0] exp3 [8] = '{6'b111001, 6'b100001, 6'b100001, 6'b100001,
                            6'b110001, 6'b110101, 6'b000001, 6'b000010};
   logic       rdy3 [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [5:0] exp4 [9] = '{6'b111001, 6'b100001, 6'b110001, 6'b100111,
                            6'b101001, 6'b110001, 6'b100001, 6'b110111, 6'b000010};
   logic [5:0] exp5 [6] = '{6'b101001, 6'b100001, 6'b110001, 6'b110101, 6'b000001, 6'b000010};
   logic [5:0] exp6 [12] = '{6'b111001, 6'b100001, 6'b100001, 6'b100101, 6'b000001, 6'b000010,
                             6'b101001, 6'b110001, 6'b110001, 6'b100101, 6'b000001, 6'b000010};

   initial begin
      reset = 1'b1;
      a_in_valid = 1'b0; a_in_data = '0; a_ser_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_ser_ready = 1'b0;
      c_in_valid = 1'b0; c_in_data = '0; c_ser_ready = 1'b0;

      // 1: reset state, then ready right after release
      to_neg();
      check_eq("t1.rst_a", a_obs, 6'b000000);
      check_eq("t1.rst_b", b_obs, 6'b000000);
      check_eq("t1.rst_c", c_obs, 6'b000000);
      to_drv();
      reset = 1'b0;
      to_neg();
      check_eq("t1.rel_a", a_obs, 6'b000010);
      to_drv();

      // 2: 1011 MSB first, no stalls, one gap cycle
      a_in_valid = 1'b1; a_in_data = 4'b1011; a_ser_ready = 1'b1;
      to_neg();
      check_eq("t2.accept", a_obs, 6'b000010);
      to_drv();
      a_in_valid = 1'b0; a_in_data = '0;
      for (int i = 0; i < 6; i++) begin
         to_neg();
         check_eq($sformatf("t2.c%0d", i), a_obs, exp2[i]);
         to_drv();
      end

      // 3: 1011 with a two-cycle stall on bit 2
      a_in_valid = 1'b1; a_in_data = 4'b1011; a_ser_ready = 1'b1;
      to_neg();
      check_eq("t3.accept", a_obs, 6'b000010);
      to_drv();
      a_in_valid = 1'b0; a_in_data = '0;
      for (int i = 0; i < 8; i++) begin
         a_ser_ready = rdy3[i];
         to_neg();
         check_eq($sformatf("t3.c%0d", i), a_obs, exp3[i]);
         to_drv();
      end

      // 4: GAP=0, A then 5 chained without a bubble; 5 is held during A's frame
      b_in_valid = 1'b1; b_in_data = 4'hA; b_ser_ready = 1'b1;
      to_neg();
      check_eq("t4.accept", b_obs, 6'b000010);
      to_drv();
      b_in_data = 4'h5;
      for (int i = 0; i < 9; i++) begin
         b_in_valid = (i <= 3);
         to_neg();
         check_eq($sformatf("t4.c%0d", i), b_obs, exp4[i]);
         to_drv();
      end

      // 5: reset mid-frame after two bits of C, then 0011 serialized complete
      a_in_valid = 1'b1; a_in_data = 4'hC; a_ser_ready = 1'b1;
      to_drv();
      a_in_valid = 1'b0; a_in_data = '0;
      to_neg();
      check_eq("t5.bit1", a_obs, 6'b111001);
      to_drv();
      to_neg();
      check_eq("t5.bit2", a_obs, 6'b110001);
      to_drv();
      reset = 1'b1;
      to_neg();
      check_eq("t5.abort", a_obs, 6'b000000);
      to_drv();
      to_neg();
      check_eq("t5.held", a_obs, 6'b000000);
      to_drv();
      reset = 1'b0;
      a_in_valid = 1'b1; a_in_data = 4'h3;
      to_neg();
      check_eq("t5.accept", a_obs, 6'b000010);
      to_drv();
      a_in_valid = 1'b0; a_in_data = '0;
      for (int i = 0; i < 6; i++) begin
         to_neg();
         check_eq($sformatf("t5.c%0d", i), a_obs, exp5[i]);
         to_drv();
      end

      // 6: LSB first 0001, next word 0110 held valid and taken only once IDLE again
      c_in_valid = 1'b1; c_in_data = 4'b0001; c_ser_ready = 1'b1;
      to_neg();
      check_eq("t6.accept", c_obs, 6'b000010);
      to_drv();
      c_in_data = 4'b0110;
      for (int i = 0; i < 12; i++) begin
         c_in_valid = (i <= 5);
         to_neg();
         check_eq($sformatf("t6.c%0d", i), c_obs, exp6[i]);
         to_drv();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
